// File: rtl/stepper_multi_driver.sv
// NCH-channel stepper move controller: per-channel DIR setup, STEP pulse train, torque hold, busy/done.
// Optional per-channel abort input is compiled in when MOVE_ABORT_EN is defined.
`timescale 1ns/1ps

module stepper_multi_driver #(
  parameter int NCH            = 2,
  parameter int STEP_W         = 8,
  parameter int SETUP_TICKS    = 1,
  parameter int PULSE_CYC      = 4,
  parameter int END_MOVE_DELAY = 50
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  step_clock,
  input  logic [NCH-1:0]        start,
  input  logic [NCH*STEP_W-1:0] steps,
  input  logic [NCH-1:0]        dir_in,
`ifdef MOVE_ABORT_EN
  input  logic [NCH-1:0]        abort,
`endif
  output logic [NCH-1:0]        step_out,
  output logic [NCH-1:0]        dir_out,
  output logic [NCH-1:0]        en_out,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        done
);

  localparam int SETUP_W = $clog2(SETUP_TICKS + 1);
  localparam int PULSE_W = $clog2(PULSE_CYC + 1);
  localparam int HOLD_W  = (END_MOVE_DELAY > 0) ? $clog2(END_MOVE_DELAY + 1) : 1;

  localparam logic [SETUP_W-1:0] SETUP_INIT = SETUP_W'(SETUP_TICKS);
  localparam logic [SETUP_W-1:0] SETUP_ONE  = SETUP_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_INIT = PULSE_W'(PULSE_CYC);
  localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(END_MOVE_DELAY);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  logic prev_step_q;
  logic tick;
  logic [NCH-1:0] abort_req;

`ifdef MOVE_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_step_q <= 1'b0;
    else          prev_step_q <= step_clock;
  end

  assign tick = step_clock & ~prev_step_q;

  // Handshake: start[i] is a one-cycle request with no ready; it is taken only in IDLE,
  // busy[i] rises on the following cycle and any start seen while busy is dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t              state_q, state_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [SETUP_W-1:0]  setup_q, setup_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_pend_q, abort_pend_d;
    logic [STEP_W-1:0]   req_steps;

    assign req_steps = steps[i*STEP_W +: STEP_W];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q      <= IDLE;
        remaining_q  <= '0;
        setup_q      <= '0;
        pulse_q      <= '0;
        hold_q       <= '0;
        step_q       <= 1'b0;
        dir_q        <= 1'b0;
        en_q         <= 1'b1;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        abort_pend_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        remaining_q  <= remaining_d;
        setup_q      <= setup_d;
        pulse_q      <= pulse_d;
        hold_q       <= hold_d;
        step_q       <= step_d;
        dir_q        <= dir_d;
        en_q         <= en_d;
        busy_q       <= busy_d;
        done_q       <= done_d;
        abort_pend_q <= abort_pend_d;
      end
    end

    always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      setup_d      = setup_q;
      pulse_d      = pulse_q;
      hold_d       = hold_q;
      step_d       = step_q;
      dir_d        = dir_q;
      en_d         = en_q;
      busy_d       = busy_q;
      done_d       = done_q;
      abort_pend_d = abort_pend_q;
      case (state_q)
        IDLE: begin
          if (start[i]) begin
            busy_d       = 1'b1;
            done_d       = 1'b0;
            abort_pend_d = 1'b0;
            if (req_steps != '0) begin
              remaining_d = req_steps;
              dir_d       = dir_in[i];
              en_d        = 1'b0;
              setup_d     = SETUP_INIT;
              state_d     = SETUP;
            end else begin
              // Empty move: a zero hold finishes on the next edge with coils untouched.
              hold_d  = '0;
              state_d = HOLD;
            end
          end
        end
        SETUP: begin
          if (abort_req[i]) begin
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end else if (tick) begin
            setup_d = setup_q - SETUP_ONE;
            if (setup_q == SETUP_ONE) state_d = RUN;
          end
        end
        RUN: begin
          if (abort_req[i]) abort_pend_d = 1'b1;
          if (step_q) begin
            // Ticks during a pulse are dropped; the pulse always runs its full width.
            if (pulse_q == PULSE_ONE) begin
              step_d = 1'b0;
              if (remaining_q == '0 || abort_pend_q || abort_req[i]) begin
                hold_d  = HOLD_INIT;
                state_d = HOLD;
              end
            end else begin
              pulse_d = pulse_q - PULSE_ONE;
            end
          end else if (abort_req[i]) begin
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end else if (tick) begin
            step_d      = 1'b1;
            pulse_d     = PULSE_INIT;
            remaining_d = remaining_q - STEP_ONE;
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            en_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (tick) begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign step_out[i] = step_q;
    assign dir_out[i]  = dir_q;
    assign en_out[i]   = en_q;
    assign busy[i]     = busy_q;
    assign done[i]     = done_q;
  end

endmodule

// File: tb/tb_stepper_multi_driver.sv
// Bench for stepper_multi_driver: table of single-channel moves plus reset, dual-channel and
// (with MOVE_ABORT_EN) abort sequences; pulses and ticks are observed on the falling clock edge.
`timescale 1ns/1ps

module tb_stepper_multi_driver;
  localparam int NCH       = 2;
  localparam int STEP_W    = 8;
  localparam int PULSE_CYC = 4;
  localparam int END_DELAY = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic step_clock = 1'b0;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] dir_in = '0;
  logic [NCH*STEP_W-1:0] steps = '0;
`ifdef MOVE_ABORT_EN
  logic [NCH-1:0] abort = '0;
`endif
  logic [NCH-1:0] step_out, dir_out, en_out, busy, done;

  int pass_cnt = 0;
  int check_cnt = 0;
  int tick_period = 10;
  int tick_phase = 0;

  logic [15:0] exp_q[$];

  int pulses[NCH], pre_ticks[NCH], tail_ticks[NCH], dropped[NCH];
  int w_min[NCH], w_max[NCH], cur_w[NCH], en_low[NCH], busy_cyc[NCH];
  logic [NCH-1:0] prev_so = '0;

  typedef struct {
    int ch;
    int nsteps;
    bit dir;
    int period;
    bit on_tick;
    bit restart;
    int exp_pulses;
    int exp_pre;
    int exp_tail;
    int exp_dropped;
    int exp_busy;
  } vec_t;

  vec_t vecs[7];

  stepper_multi_driver #(
    .NCH(NCH), .STEP_W(STEP_W), .SETUP_TICKS(1), .PULSE_CYC(PULSE_CYC), .END_MOVE_DELAY(END_DELAY)
  ) dut (
    .clock(clock), .reset_n(reset_n), .step_clock(step_clock),
    .start(start), .steps(steps), .dir_in(dir_in),
`ifdef MOVE_ABORT_EN
    .abort(abort),
`endif
    .step_out(step_out), .dir_out(dir_out), .en_out(en_out), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  // step_clock: one clock high every tick_period clocks
  initial begin
    forever begin
      @(posedge clock);
      #1;
      step_clock = (tick_phase == 0);
      if (tick_phase >= tick_period - 1) tick_phase = 0;
      else tick_phase++;
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clock);
      for (int c = 0; c < NCH; c++) begin
        if (step_out[c] && !prev_so[c]) begin
          if (pulses[c] == 0) pre_ticks[c] = tail_ticks[c];
          pulses[c]++;
          cur_w[c] = 1;
          tail_ticks[c] = 0;
        end else if (step_out[c]) begin
          cur_w[c]++;
        end
        if (!step_out[c] && prev_so[c]) begin
          if (cur_w[c] < w_min[c]) w_min[c] = cur_w[c];
          if (cur_w[c] > w_max[c]) w_max[c] = cur_w[c];
        end
        if (step_clock && step_out[c]) dropped[c]++;
        if (step_clock && !step_out[c] && !en_out[c]) tail_ticks[c]++;
        if (!en_out[c]) en_low[c]++;
        if (busy[c]) busy_cyc[c]++;
      end
      prev_so = step_out;
    end
  end

  function automatic void chk(input string name, input int act, input int exp_v);
    check_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endfunction

  task automatic clear_stats();
    for (int c = 0; c < NCH; c++) begin
      pulses[c] = 0; pre_ticks[c] = 0; tail_ticks[c] = 0; dropped[c] = 0;
      w_min[c] = 1000; w_max[c] = 0; cur_w[c] = 0; en_low[c] = 0; busy_cyc[c] = 0;
    end
  endtask

  // driver: one-cycle start, optionally aligned onto a tick cycle; returns at the next negedge
  task automatic drive_start(input logic [NCH-1:0] mask, input logic [NCH*STEP_W-1:0] st,
                             input logic [NCH-1:0] d, input bit on_tick);
    int g;
    g = 0;
    @(posedge clock); #2;
    while ((step_clock != on_tick) && g < 200) begin
      @(posedge clock); #2;
      g++;
    end
    start = mask; steps = st; dir_in = d;
    @(posedge clock); #2;
    start = '0;
    @(negedge clock);
  endtask

  task automatic wait_done(input int ch, input int limit, input string tag);
    int n;
    n = 0;
    while (!(done[ch] && !busy[ch]) && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " done_reached"}, int'(done[ch] && !busy[ch]), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " step_out"}, int'(step_out), 0);
    chk({tag, " dir_out"}, int'(dir_out), 0);
    chk({tag, " en_out"}, int'(en_out), 3);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    logic [NCH*STEP_W-1:0] st;
    logic [NCH-1:0] mask, d;
    int n;
    string tg;

    //            ch stp dir  per tick  rst   pul pre tail drop busy
    vecs[0] = '{0, 3,   1'b1, 10, 1'b0, 1'b0, 3,   2,  2,   0,   -1};
    vecs[1] = '{1, 0,   1'b1, 10, 1'b0, 1'b0, 0,   0,  0,   0,    1};
    vecs[2] = '{0, 3,   1'b1, 10, 1'b1, 1'b0, 3,   2,  2,   0,   -1};
    vecs[3] = '{0, 3,   1'b1, 3,  1'b0, 1'b0, 3,   2,  2,   3,   -1};
    vecs[4] = '{0, 3,   1'b1, 10, 1'b0, 1'b1, 3,   2,  2,   0,   -1};
    vecs[5] = '{0, 1,   1'b0, 5,  1'b0, 1'b0, 1,   2,  2,   0,   -1};
    vecs[6] = '{1, 255, 1'b1, 5,  1'b0, 1'b0, 255, 2,  2,   0,   -1};

    clear_stats();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_idle_outputs("reset");

    for (int k = 0; k < 7; k++) begin
      tg = $sformatf("v%0d", k);
      tick_period = vecs[k].period;
      repeat (2) @(negedge clock);
      clear_stats();
      exp_q.push_back(16'(vecs[k].exp_pulses));
      st = '0;
      st[vecs[k].ch*STEP_W +: STEP_W] = STEP_W'(vecs[k].nsteps);
      mask = '0; mask[vecs[k].ch] = 1'b1;
      d = '0; d[vecs[k].ch] = vecs[k].dir;
      drive_start(mask, st, d, vecs[k].on_tick);
      chk({tg, " en_after_start"}, int'(en_out[vecs[k].ch]), (vecs[k].nsteps == 0) ? 1 : 0);
      chk({tg, " busy_after_start"}, int'(busy[vecs[k].ch]), 1);
      chk({tg, " done_after_start"}, int'(done[vecs[k].ch]), 0);
      if (vecs[k].nsteps != 0) chk({tg, " dir_after_start"}, int'(dir_out[vecs[k].ch]), int'(vecs[k].dir));
      if (vecs[k].restart) begin
        repeat (3) @(posedge clock);
        #2;
        start[vecs[k].ch] = 1'b1;
        steps[vecs[k].ch*STEP_W +: STEP_W] = 8'd5;
        dir_in[vecs[k].ch] = ~vecs[k].dir;
        @(posedge clock); #2;
        start = '0;
        @(negedge clock);
      end
      wait_done(vecs[k].ch, 3000, tg);
      chk({tg, " pulses"}, pulses[vecs[k].ch], int'(exp_q.pop_front()));
      chk({tg, " pre_ticks"}, pre_ticks[vecs[k].ch], vecs[k].exp_pre);
      chk({tg, " hold_ticks"}, tail_ticks[vecs[k].ch], vecs[k].exp_tail);
      chk({tg, " dropped_ticks"}, dropped[vecs[k].ch], vecs[k].exp_dropped);
      chk({tg, " en_released"}, int'(en_out[vecs[k].ch]), 1);
      if (vecs[k].nsteps != 0) begin
        chk({tg, " width_min"}, w_min[vecs[k].ch], PULSE_CYC);
        chk({tg, " width_max"}, w_max[vecs[k].ch], PULSE_CYC);
        chk({tg, " dir_held"}, int'(dir_out[vecs[k].ch]), int'(vecs[k].dir));
      end else begin
        chk({tg, " en_never_low"}, en_low[vecs[k].ch], 0);
      end
      if (vecs[k].exp_busy >= 0) chk({tg, " busy_cycles"}, busy_cyc[vecs[k].ch], vecs[k].exp_busy);
    end

    // two channels started together
    tick_period = 10;
    repeat (2) @(negedge clock);
    clear_stats();
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd4);
    drive_start(2'b11, {8'd4, 8'd2}, 2'b01, 1'b0);
    chk("dual busy_after_start", int'(busy), 3);
    chk("dual en_after_start", int'(en_out), 0);
    chk("dual dir_after_start", int'(dir_out), 1);
    wait_done(0, 2000, "dual ch0");
    chk("dual ch1_busy_at_ch0_done", int'(busy[1]), 1);
    chk("dual ch0 pulses", pulses[0], int'(exp_q.pop_front()));
    wait_done(1, 2000, "dual ch1");
    chk("dual ch1 pulses", pulses[1], int'(exp_q.pop_front()));
    chk("dual ch1 hold_ticks", tail_ticks[1], END_DELAY);
    chk("dual ch1 width_max", w_max[1], PULSE_CYC);

    // reset asserted in the middle of a pulse
    repeat (2) @(negedge clock);
    clear_stats();
    drive_start(2'b01, {8'd0, 8'd5}, 2'b01, 1'b0);
    n = 0;
    while (!step_out[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("midrst pulse_reached", int'(step_out[0]), 1);
    #1 reset_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst busy_after_release", int'(busy), 0);

`ifdef MOVE_ABORT_EN
    // abort during the second pulse of a six-step move
    tick_period = 10;
    repeat (2) @(negedge clock);
    clear_stats();
    exp_q.push_back(16'd2);
    drive_start(2'b01, {8'd0, 8'd6}, 2'b01, 1'b0);
    n = 0;
    while (pulses[0] < 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("abort second_pulse_reached", pulses[0], 2);
    @(posedge clock); #2;
    abort = 2'b01;
    @(posedge clock); #2;
    abort = '0;
    wait_done(0, 2000, "abort");
    chk("abort pulses", pulses[0], int'(exp_q.pop_front()));
    chk("abort width_min", w_min[0], PULSE_CYC);
    chk("abort width_max", w_max[0], PULSE_CYC);
    chk("abort hold_ticks", tail_ticks[0], END_DELAY);
    chk("abort en_released", int'(en_out[0]), 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
